// File: rtl/aes_out_credit_fifo_if.sv
// Handshake bundle between the AES output FIFO and its neighbours.
// Carries issue credits, core ciphertext and the out_V stream.
interface aes_out_credit_fifo_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 4
);
  logic              issue_V;
  logic              issue_ready;
  logic [DATA_W-1:0] enc_V;
  logic              enc_valid_V;
  logic [DATA_W-1:0] out_V_din;
  logic              out_V_full_n;
  logic              out_V_write;
  logic [ADDR_W:0]   level;
  logic              err;

  modport master (
    output issue_V,
    output enc_V,
    output enc_valid_V,
    output out_V_full_n,
    input  issue_ready,
    input  out_V_din,
    input  out_V_write,
    input  level,
    input  err
  );

  modport slave (
    input  issue_V,
    input  enc_V,
    input  enc_valid_V,
    input  out_V_full_n,
    output issue_ready,
    output out_V_din,
    output out_V_write,
    output level,
    output err
  );
endinterface

// File: rtl/aes_out_credit_fifo.sv
// Ciphertext capture FIFO behind the AES-128 core with issue credits.
// Credits bound blocks in flight so a valid-only return always has room.
module aes_out_credit_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic ap_clk,
  input logic ap_rst,
  aes_out_credit_fifo_if.slave bus
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W+1:0] DEPTH_S = (ADDR_W+2)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   inflight;
  logic              err_q;

  logic [ADDR_W+1:0] credit_sum;
  logic              ready;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              issue_acc;
  logic              ret;
  logic              err_set;
  logic [ADDR_W:0]   count_nx;
  logic [ADDR_W:0]   inflight_nx;

  assign credit_sum = {1'b0, count} + {1'b0, inflight};
  assign ready      = credit_sum < DEPTH_S;
  assign full       = count == DEPTH_C;
  assign empty      = count == '0;
  assign pop        = !empty && bus.out_V_full_n;
  assign push       = bus.enc_valid_V && (!full || pop);
  assign issue_acc  = bus.issue_V && ready;
  assign ret        = bus.enc_valid_V && (inflight != '0);

  assign err_set = (bus.issue_V && !ready)
                || (bus.enc_valid_V && inflight == '0)
                || (bus.enc_valid_V && !push);

  // next occupancy and credit counts
  always_comb begin
    count_nx    = count;
    inflight_nx = inflight
                + (ADDR_W+1)'(issue_acc)
                - (ADDR_W+1)'(ret);
    unique case ({push, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  // pointer, counter and sticky error state
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nx;
      inflight <= inflight_nx;
      if (err_set) err_q <= 1'b1;
    end
  end

  // block storage; contents survive reset, pointers do not
  always_ff @(posedge ap_clk) begin
    if (push && !ap_rst) mem[wr_ptr] <= bus.enc_V;
  end

  assign bus.issue_ready = ready;
  assign bus.out_V_write = pop;
  assign bus.out_V_din   = empty ? '0 : mem[rd_ptr];
  assign bus.level       = count;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_aes_out_credit_fifo.sv
// Directed bench for the AES output credit FIFO.
// Vector table for the basic path, hand sequences for full/stall/reset.
module tb_aes_out_credit_fifo;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam logic [127:0] KCT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2  = 128'hdeadbeef_00112233_44556677_8899aabb;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  aes_out_credit_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  aes_out_credit_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus(bus)
  );

  typedef struct {
    logic         iss;
    logic         ev;
    logic [127:0] enc;
    logic         fn;
    logic         w;
    logic [127:0] din;
    logic [4:0]   lvl;
    logic         rdy;
    logic         er;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iss, input logic ev,
                       input logic [127:0] d, input logic fn);
    bus.issue_V      = iss;
    bus.enc_valid_V  = ev;
    bus.enc_V        = d;
    bus.out_V_full_n = fn;
  endtask

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset;
    drive(1'b0, 1'b0, '0, 1'b1);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
  endtask

  task automatic issue_n(input int n, input logic fn);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, '0, fn);
      tick();
    end
  endtask

  task automatic ret_n(input int n, input logic [127:0] base);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, base + 128'(i), 1'b0);
      tick();
    end
  endtask

  vec_t tv[8];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int sent;
    int got;
    logic prev_stall;
    logic [127:0] prev_din;

    tv[0] = '{1'b1, 1'b0, '0,  1'b1, 1'b0, '0,  5'd0, 1'b1, 1'b0};
    tv[1] = '{1'b0, 1'b1, KCT, 1'b1, 1'b0, '0,  5'd0, 1'b1, 1'b0};
    tv[2] = '{1'b0, 1'b0, '0,  1'b1, 1'b1, KCT, 5'd1, 1'b1, 1'b0};
    tv[3] = '{1'b0, 1'b0, '0,  1'b1, 1'b0, '0,  5'd0, 1'b1, 1'b0};
    tv[4] = '{1'b0, 1'b1, K2,  1'b0, 1'b0, '0,  5'd0, 1'b1, 1'b0};
    tv[5] = '{1'b0, 1'b0, '0,  1'b0, 1'b0, K2,  5'd1, 1'b1, 1'b1};
    tv[6] = '{1'b0, 1'b0, '0,  1'b1, 1'b1, K2,  5'd1, 1'b1, 1'b1};
    tv[7] = '{1'b0, 1'b0, '0,  1'b1, 1'b0, '0,  5'd0, 1'b1, 1'b1};

    drive(1'b0, 1'b0, '0, 1'b1);
    repeat (2) tick();
    do_reset();
    #1;
    chk("rst_level", 128'(bus.level), 128'd0);
    chk("rst_write", 128'(bus.out_V_write), 128'd0);
    chk("rst_din", bus.out_V_din, 128'd0);
    chk("rst_ready", 128'(bus.issue_ready), 128'd1);
    chk("rst_err", 128'(bus.err), 128'd0);

    // single block path, then a return with no credit outstanding
    for (int i = 0; i < 8; i++) begin
      drive(tv[i].iss, tv[i].ev, tv[i].enc, tv[i].fn);
      #1;
      chk($sformatf("tv%0d_write", i), 128'(bus.out_V_write), 128'(tv[i].w));
      chk($sformatf("tv%0d_din", i), bus.out_V_din, tv[i].din);
      chk($sformatf("tv%0d_level", i), 128'(bus.level), 128'(tv[i].lvl));
      chk($sformatf("tv%0d_ready", i), 128'(bus.issue_ready), 128'(tv[i].rdy));
      chk($sformatf("tv%0d_err", i), 128'(bus.err), 128'(tv[i].er));
      tick();
    end

    // credit exhaustion
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, '0, 1'b1);
      #1;
      chk($sformatf("cred_ready%0d", i), 128'(bus.issue_ready), 128'd1);
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("cred_ready_after16", 128'(bus.issue_ready), 128'd0);
    chk("cred_err_before17", 128'(bus.err), 128'd0);
    drive(1'b1, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("cred_err_after17", 128'(bus.err), 128'd1);
    chk("cred_ready_after17", 128'(bus.issue_ready), 128'd0);

    // fill with sink blocked, then drain in order
    do_reset();
    issue_n(DEPTH, 1'b0);
    ret_n(DEPTH, 128'd0);
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("blk_level", 128'(bus.level), 128'd16);
    chk("blk_din", bus.out_V_din, 128'd0);
    chk("blk_write", 128'(bus.out_V_write), 128'd0);
    chk("blk_ready", 128'(bus.issue_ready), 128'd0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      #1;
      chk($sformatf("drain_write%0d", i), 128'(bus.out_V_write), 128'd1);
      chk($sformatf("drain_din%0d", i), bus.out_V_din, 128'(i));
      tick();
    end
    #1;
    chk("drain_level", 128'(bus.level), 128'd0);
    chk("drain_ready", 128'(bus.issue_ready), 128'd1);
    chk("drain_err", 128'(bus.err), 128'd0);

    // push into a full FIFO while popping
    do_reset();
    issue_n(DEPTH, 1'b0);
    ret_n(DEPTH, 128'd100);
    drive(1'b0, 1'b1, 128'd200, 1'b1);
    #1;
    chk("fullpp_write", 128'(bus.out_V_write), 128'd1);
    chk("fullpp_din", bus.out_V_din, 128'd100);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("fullpp_level", 128'(bus.level), 128'd16);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      #1;
      chk($sformatf("fullpp_din%0d", i), bus.out_V_din,
          (i == DEPTH - 1) ? 128'd200 : 128'(101 + i));
      tick();
    end
    #1;
    chk("fullpp_empty", 128'(bus.level), 128'd0);

    // stream with the sink toggling every cycle
    do_reset();
    issue_n(12, 1'b1);
    sent = 0;
    got = 0;
    prev_stall = 1'b0;
    prev_din = '0;
    for (int c = 0; c < 80; c++) begin
      if (sent == 12 && got == 12) break;
      drive(1'b0, sent < 12, 128'(500 + sent), c[0]);
      #1;
      if (prev_stall)
        chk($sformatf("tog_stable%0d", c), bus.out_V_din, prev_din);
      if (bus.out_V_write) begin
        chk($sformatf("tog_din%0d", got), bus.out_V_din, 128'(500 + got));
        got++;
      end
      prev_stall = !bus.out_V_write && (bus.level != '0);
      prev_din = bus.out_V_din;
      if (sent < 12) sent++;
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("tog_count", 128'(got), 128'd12);
    chk("tog_level", 128'(bus.level), 128'd0);
    chk("tog_err", 128'(bus.err), 128'd0);

    // reset mid-operation
    do_reset();
    issue_n(8, 1'b0);
    ret_n(5, 128'd7);
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("mid_level", 128'(bus.level), 128'd5);
    chk("mid_din", bus.out_V_din, 128'd7);
    drive(1'b1, 1'b1, 128'd99, 1'b1);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("mid_rst_level", 128'(bus.level), 128'd0);
    chk("mid_rst_ready", 128'(bus.issue_ready), 128'd1);
    chk("mid_rst_write", 128'(bus.out_V_write), 128'd0);
    chk("mid_rst_err", 128'(bus.err), 128'd0);
    chk("mid_rst_din", bus.out_V_din, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
